// File: rtl/add_fu_pkg.sv
// add_fu_pkg: shared widths, opcode enum and result-entry layout for the add unit.
package add_fu_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned QDEPTH    = 2;
  localparam int unsigned RES_TAG_W = 6;

  typedef enum logic {OP_ADD, OP_SUB} add_op_e;

  // Default-width view of one queued CDB result.
  typedef struct packed {
    logic [RES_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    value;
  } res_entry_t;

endpackage

// File: rtl/add_fu_outq.sv
// add_fu_outq: 2-entry tagged result FIFO feeding the CDB; push and pop may coincide.
module add_fu_outq
  import add_fu_pkg::*;
#(
  parameter int unsigned TAG_W = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               push,
  input  logic [TAG_W-1:0]                   push_tag,
  input  logic [DATA_W-1:0]                  push_value,
  input  logic                               pop,
  output logic [TAG_W-1:0]                   head_tag,
  output logic [DATA_W-1:0]                  head_value,
  output logic [$clog2(QDEPTH+1)-1:0]        count,
  output logic                               full
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [TAG_W-1:0]  tag_q   [QDEPTH];
  logic [TAG_W-1:0]  tag_d   [QDEPTH];
  logic [DATA_W-1:0] value_q [QDEPTH];
  logic [DATA_W-1:0] value_d [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Next-state: flush wins over any push/pop in the same cycle.
  always_comb begin
    tag_d    = tag_q;
    value_d  = value_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        tag_d[wr_ptr_q]   = push_tag;
        value_d[wr_ptr_q] = push_value;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        tag_q[i]   <= '0;
        value_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_q    <= tag_d;
      value_q  <= value_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_tag   = tag_q[rd_ptr_q];
  assign head_value = value_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(QDEPTH));

endmodule

// File: rtl/adder64.sv
// adder64: 64-bit ripple-carry adder, carry-out discarded (modulo 2^64).
module adder64
  import add_fu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  // Bit-serial carry chain, LSB first.
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/add_fu.sv
// add_fu: integer add/sub functional unit, RS -> S1 register -> adder -> 2-entry CDB queue.
// Optional macro ADD_FU_SUB_EN builds the subtract path (second adder instance).
module add_fu
  import add_fu_pkg::*;
#(
  parameter int unsigned TAG_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_op,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic              s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;

  logic              accept_c, s1_adv_c, push_c, pop_c;
  logic [DATA_W-1:0] result_c;
  logic [CNT_W-1:0]  q_count;
  logic              q_full;

`ifdef ADD_FU_SUB_EN
  add_op_e           s1_op_q, s1_op_d;
  logic [DATA_W-1:0] b_sel_c, sum_c;

  // Subtract is a + ~b, then +1 through the second adder.
  assign b_sel_c = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;

  adder64 u_add (.a(s1_a_q), .b(b_sel_c),                        .sum(sum_c));
  adder64 u_inc (.a(sum_c),  .b(DATA_W'(s1_op_q == OP_SUB)),     .sum(result_c));
`else
  logic unused_issue_op;
  assign unused_issue_op = issue_op;

  adder64 u_add (.a(s1_a_q), .b(s1_b_q), .sum(result_c));
`endif

  // Handshake and queue control; flush kills both sides of every transfer.
  assign cdb_valid   = (q_count != '0) && !flush;
  assign pop_c       = cdb_valid && cdb_ready;
  assign s1_adv_c    = s1_valid_q && (!q_full || pop_c);
  assign push_c      = s1_adv_c && !flush;
  assign issue_ready = !flush && rst_n && (!s1_valid_q || s1_adv_c);
  assign accept_c    = issue_valid && issue_ready;
  assign busy        = s1_valid_q || (q_count != '0);

  // S1 next-state: load on accept, drain on advance, clear on flush.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
`ifdef ADD_FU_SUB_EN
    s1_op_d    = s1_op_q;
`endif
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_tag_d   = issue_tag;
      s1_a_d     = issue_a;
      s1_b_d     = issue_b;
`ifdef ADD_FU_SUB_EN
      s1_op_d    = add_op_e'(issue_op);
`endif
    end else if (s1_adv_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // S1 operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
`ifdef ADD_FU_SUB_EN
      s1_op_q    <= OP_ADD;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
`ifdef ADD_FU_SUB_EN
      s1_op_q    <= s1_op_d;
`endif
    end
  end

  add_fu_outq #(.TAG_W(TAG_W)) u_outq (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push_c),
    .push_tag   (s1_tag_q),
    .push_value (result_c),
    .pop        (pop_c),
    .head_tag   (cdb_tag),
    .head_value (cdb_value),
    .count      (q_count),
    .full       (q_full)
  );

endmodule
